// File: rtl/shift_sequencer.sv
// shift_sequencer
//
// Multi-cycle controller for a shared, external, purely combinational
// 32-bit logical-right barrel shifter. It runs SRL, SLL, SRA and ROR for
// the EX stage by conditioning the shifter operand and result:
//   SLL : bit-reverse the operand in, bit-reverse the result out
//   SRA : for negative operands, invert in and invert out
//   ROR : two passes, (d >> s) | (d << (32 - s)), where the left shift
//         is done as a bit-reversed right shift
//
// Configuration macro: SHIFT_SEQ_ROR_EN
//   defined   : ROR is supported (PASS2 state and partial register present)
//   undefined : op 11 executes as SRL with single-pass latency
//
// Ports
//   clk        in   1  clock
//   rst        in   1  asynchronous active-high reset
//   req_valid  in   1  request present
//   req_ready  out  1  request accepted when high (IDLE only)
//   req_op     in   2  00 SRL, 01 SLL, 10 SRA, 11 ROR
//   req_data   in  32  operand
//   req_shamt  in   5  shift amount
//   rsp_valid  out  1  result valid (DONE)
//   rsp_ready  in   1  consumer accepts result
//   rsp_data   out 32  registered result
//   busy       out  1  high whenever not IDLE
//   sh_a       out 32  operand to external shifter
//   sh_shamt   out 32  shift amount to external shifter, [31:5] always 0
//   sh_out     in  32  combinational shifter result
module shift_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data,
  input  logic [4:0]  req_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [31:0] sh_a,
  output logic [31:0] sh_shamt,
  input  logic [31:0] sh_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_data;
  logic [4:0]  r_shamt;
  logic [31:0] r_rsp_data;

  logic [31:0] w_sh_a;
  logic [31:0] w_sh_shamt;
  logic [31:0] w_pass1_res;

`ifdef SHIFT_SEQ_ROR_EN
  logic [31:0] r_partial;
  logic [5:0]  w_ror_amt;

  // Left-shift amount for the second ROR pass; shamt is never 0 here.
  assign w_ror_amt = 6'd32 - {1'b0, r_shamt};
`endif

  // Operand conditioning toward the shifter; zero outside the pass states.
  always_comb begin
    w_sh_a     = '0;
    w_sh_shamt = '0;
    case (r_state)
      S_PASS1: begin
        w_sh_shamt = {27'b0, r_shamt};
        case (r_op)
          OP_SLL:  w_sh_a = bitrev(r_data);
          OP_SRA:  w_sh_a = r_data[31] ? ~r_data : r_data;
          default: w_sh_a = r_data;
        endcase
      end
`ifdef SHIFT_SEQ_ROR_EN
      S_PASS2: begin
        w_sh_a     = bitrev(r_data);
        w_sh_shamt = {27'b0, w_ror_amt[4:0]};
      end
`endif
      default: begin
        w_sh_a     = '0;
        w_sh_shamt = '0;
      end
    endcase
  end

  // Result post-conditioning for the first pass.
  always_comb begin
    w_pass1_res = sh_out;
    case (r_op)
      OP_SLL:  w_pass1_res = bitrev(sh_out);
      OP_SRA:  w_pass1_res = r_data[31] ? ~sh_out : sh_out;
      default: w_pass1_res = sh_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_data     <= '0;
      r_shamt    <= '0;
      r_rsp_data <= '0;
`ifdef SHIFT_SEQ_ROR_EN
      r_partial  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_data  <= req_data;
            r_shamt <= req_shamt;
            r_state <= S_PASS1;
          end
        end
        S_PASS1: begin
`ifdef SHIFT_SEQ_ROR_EN
          // ROR by 0 is the operand itself, so it finishes in one pass.
          if (r_op == OP_ROR && r_shamt != 5'd0) begin
            r_partial <= sh_out;
            r_state   <= S_PASS2;
          end else begin
            r_rsp_data <= w_pass1_res;
            r_state    <= S_DONE;
          end
`else
          r_rsp_data <= w_pass1_res;
          r_state    <= S_DONE;
`endif
        end
        S_PASS2: begin
`ifdef SHIFT_SEQ_ROR_EN
          r_rsp_data <= r_partial | bitrev(sh_out);
          r_state    <= S_DONE;
`else
          r_state    <= S_IDLE;
`endif
        end
        S_DONE: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rsp_data;
  assign sh_a      = w_sh_a;
  assign sh_shamt  = w_sh_shamt;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic [4:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] sh_a;
  logic [31:0] sh_shamt;
  logic [31:0] sh_out;

  int n_cmp;
  int n_err;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .sh_a      (sh_a),
    .sh_shamt  (sh_shamt),
    .sh_out    (sh_out)
  );

  // External logical-right barrel shifter.
  assign sh_out = sh_a >> sh_shamt[4:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, follow it to DONE, optionally hold backpressure,
  // then release it. lat is the number of cycles from accept to rsp_valid.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_a,
                        input logic [31:0] exp, input int lat, input int bp);
    int c;
    logic [31:0] held;
    @(negedge clk);
    check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_data = d; req_shamt = s; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_p1_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_p1_shamt"}, sh_shamt, {27'b0, s});
    check({tag, "_p1_a"}, sh_a, exp_a);
    c = 0;
    while (!rsp_valid && c < 8) begin
      @(negedge clk);
      c++;
      if (c == 1 && !rsp_valid)
        check({tag, "_p2_shamt"}, sh_shamt, 32'(6'd32 - {1'b0, s}) & 32'h1F);
    end
    check({tag, "_lat"}, 32'(c), 32'(lat));
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_done_a"}, sh_a, 32'd0);
    held = rsp_data;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_data = 32'hDEADBEEF; req_op = 2'b00; req_shamt = 5'd1;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_bp_data"}, rsp_data, held);
      check({tag, "_bp_vld"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_bp_rdy"}, {31'b0, req_ready}, 32'd0);
      check({tag, "_bp_busy"}, {31'b0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle"}, {30'b0, req_ready, busy}, 32'd2);
    check({tag, "_idle_vld"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0; req_shamt = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_rdy", {31'b0, req_ready}, 32'd1);
    check("rst_vld", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_sha", sh_a, 32'd0);
    check("rst_shamt", sh_shamt, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op("srl31",  2'b00, 32'h80000000, 5'd31, 32'h80000000, 32'h00000001, 1, 0);
    run_op("sll4",   2'b01, 32'h00000001, 5'd4,  32'h80000000, 32'h00000010, 1, 0);
    run_op("sll31",  2'b01, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("sraneg", 2'b10, 32'hF0000000, 5'd4,  32'h0FFFFFFF, 32'hFF000000, 1, 0);
    run_op("srapos", 2'b10, 32'h70000000, 5'd4,  32'h70000000, 32'h07000000, 1, 0);
    run_op("sra0",   2'b10, 32'h80000000, 5'd0,  32'h7FFFFFFF, 32'h80000000, 1, 0);
`ifdef SHIFT_SEQ_ROR_EN
    run_op("ror8",   2'b11, 32'h12345678, 5'd8,  32'h12345678, 32'h78123456, 2, 0);
`else
    run_op("ror8",   2'b11, 32'h12345678, 5'd8,  32'h12345678, 32'h00123456, 1, 0);
`endif
    run_op("ror0",   2'b11, 32'h12345678, 5'd0,  32'h12345678, 32'h12345678, 1, 0);

    // Backpressure in DONE with req_valid pulsing, then a normal request.
    run_op("bp",     2'b00, 32'hA5A50000, 5'd16, 32'hA5A50000, 32'h0000A5A5, 1, 5);
    run_op("postbp", 2'b01, 32'h0000000F, 5'd8,  32'hF0000000, 32'h00000F00, 1, 0);

    // Reset in flight: in PASS2 for the ROR build, PASS1 otherwise.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_data = 32'h12345678; req_shamt = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef SHIFT_SEQ_ROR_EN
    @(negedge clk);
    check("inflight_p2", sh_shamt, 32'd24);
`endif
    rst = 1'b1;
    #1;
    check("arst_rdy", {31'b0, req_ready}, 32'd1);
    check("arst_vld", {31'b0, rsp_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_data", rsp_data, 32'd0);
    check("arst_sha", sh_a, 32'd0);
    check("arst_shamt", sh_shamt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_novld", {31'b0, rsp_valid}, 32'd0);
    end
    run_op("after_rst", 2'b00, 32'h00000100, 5'd8, 32'h00000100, 32'h00000001, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
